// File: rtl/gam_memory_layer_param_pkg.sv
// gam_memory_layer_param_pkg: shared types, default sizes, FSM states and distance helper for the GAM memory layer.
package gam_memory_layer_param_pkg;
    localparam int NODES_DEF    = 16;
    localparam int DIM_DEF      = 8;
    localparam int ELEM_W_DEF   = 8;
    localparam int CLASS_W_DEF  = 4;
    localparam int LR_SHIFT_DEF = 2;
    localparam int DIST_W_DEF   = 2*ELEM_W_DEF + $clog2(DIM_DEF);
    typedef logic [ELEM_W_DEF-1:0]         elem_t;
    typedef logic [CLASS_W_DEF-1:0]        class_t;
    typedef logic [DIST_W_DEF-1:0]         dist_t;
    typedef logic [$clog2(NODES_DEF)-1:0]  node_idx_t;
    typedef elem_t [DIM_DEF-1:0]           vec_t;
    typedef enum logic [2:0] {IDLE, SEARCH, UPDATE, ASSOC, DONE} mem_state_t;
    function automatic dist_t sq_dist(input vec_t a, input vec_t b);
        dist_t s;
        elem_t ad;
        s = '0;
        for (int k = 0; k < DIM_DEF; k++) begin
            ad = a[k] > b[k] ? a[k] - b[k] : b[k] - a[k];
            s = s + dist_t'(ad) * dist_t'(ad);
        end
        return s;
    endfunction
endpackage

// File: rtl/gam_memory_layer_param_two_min_tracker.sv
// gam_two_min_tracker: streams distances and keeps the smallest and second-smallest with their indices.
module gam_two_min_tracker #(
    parameter int DIST_W = 19,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              en,
    input  logic [DIST_W-1:0] d,
    input  logic [IDX_W-1:0]  idx,
    output logic [DIST_W-1:0] min1,
    output logic [DIST_W-1:0] min2,
    output logic [IDX_W-1:0]  idx1,
    output logic [IDX_W-1:0]  idx2,
    output logic              valid2
);
    logic valid1;
    // strict compares: an equal distance never displaces an earlier (lower) index
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            min1   <= '1;
            min2   <= '1;
            idx1   <= '0;
            idx2   <= '0;
            valid1 <= 1'b0;
            valid2 <= 1'b0;
        end else if (en) begin
            if (!valid1 || d < min1) begin
                min2   <= min1;
                idx2   <= idx1;
                valid2 <= valid1;
                min1   <= d;
                idx1   <= idx;
                valid1 <= 1'b1;
            end else if (!valid2 || d < min2) begin
                min2   <= d;
                idx2   <= idx;
                valid2 <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/gam_memory_layer_param.sv
// gam_memory_layer_param: learns class-labelled prototype nodes via a sequential two-min
// search, inserting nodes or nudging the winner, then hands off to the associative layer.
module gam_memory_layer_param
    import gam_memory_layer_param_pkg::*;
#(
    parameter int NODES    = NODES_DEF,
    parameter int DIM      = DIM_DEF,
    parameter int ELEM_W   = ELEM_W_DEF,
    parameter int CLASS_W  = CLASS_W_DEF,
    parameter int LR_SHIFT = LR_SHIFT_DEF,
    localparam int DIST_W  = 2*ELEM_W + $clog2(DIM),
    localparam int IDX_W   = $clog2(NODES),
    localparam int CNT_W   = $clog2(NODES+1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DIM*ELEM_W-1:0] x,
    input  logic [CLASS_W-1:0]    c,
    input  logic                  x_valid,
    output logic                  x_ready,
    input  logic [DIST_W-1:0]     thresh,
    input  logic                  learning_done,
    input  logic                  assoc_learning_done,
    output logic                  assoc_learning_start,
    output logic [CNT_W-1:0]      node_count,
    output logic [IDX_W-1:0]      winner_idx,
    output logic                  winner_valid,
    output logic                  overflow
);
    mem_state_t state, state_nx;
    logic [DIM*ELEM_W-1:0] xr, w_upd;
    logic [CLASS_W-1:0]    cr;
    logic [DIM*ELEM_W-1:0] w     [NODES];
    logic [CLASS_W-1:0]    cls   [NODES];
    logic [NODES-1:0]      edges [NODES];
    logic [IDX_W-1:0]      scan, idx1, idx2;
    logic [DIST_W-1:0]     d, min1, unused_min2;
    logic pending, valid2, take, last, insert, full;

    function automatic logic [DIST_W-1:0] sq(input logic [ELEM_W-1:0] a, input logic [ELEM_W-1:0] b);
        logic [ELEM_W-1:0] ad;
        ad = a > b ? a - b : b - a;
        return DIST_W'(ad) * DIST_W'(ad);
    endfunction

    // signed (ELEM_W+1)-bit step keeps the result inside 0..2^ELEM_W-1
    function automatic logic [ELEM_W-1:0] step(input logic [ELEM_W-1:0] a, input logic [ELEM_W-1:0] b);
        logic signed [ELEM_W:0] diff;
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        return ELEM_W'($signed({1'b0, b}) + (diff >>> LR_SHIFT));
    endfunction

    assign x_ready              = state == IDLE;
    assign assoc_learning_start = state == ASSOC;
    assign take                 = state == IDLE && x_valid;
    assign last                 = CNT_W'(scan) + CNT_W'(1) >= node_count;
    assign full                 = node_count == CNT_W'(NODES);
    assign insert               = node_count < CNT_W'(2) || min1 > thresh || cls[idx1] != cr;

    always_comb begin
        d     = '0;
        w_upd = w[idx1];
        for (int k = 0; k < DIM; k++) begin
            d = d + sq(xr[k*ELEM_W +: ELEM_W], w[scan][k*ELEM_W +: ELEM_W]);
            w_upd[k*ELEM_W +: ELEM_W] = step(xr[k*ELEM_W +: ELEM_W], w[idx1][k*ELEM_W +: ELEM_W]);
        end
    end

    gam_two_min_tracker #(.DIST_W(DIST_W), .IDX_W(IDX_W)) u_tracker (
        .clk    (clk),
        .reset  (reset),
        .clear  (take),
        .en     (state == SEARCH && node_count != '0),
        .d      (d),
        .idx    (scan),
        .min1   (min1),
        .min2   (unused_min2),
        .idx1   (idx1),
        .idx2   (idx2),
        .valid2 (valid2)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = x_valid ? SEARCH : (pending || learning_done) ? ASSOC : IDLE;
            SEARCH:  state_nx = last ? UPDATE : SEARCH;
            UPDATE:  state_nx = IDLE;
            ASSOC:   state_nx = assoc_learning_done ? DONE : ASSOC;
            default: state_nx = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            node_count   <= '0;
            winner_idx   <= '0;
            winner_valid <= 1'b0;
            overflow     <= 1'b0;
            pending      <= 1'b0;
            scan         <= '0;
            for (int i = 0; i < NODES; i++) edges[i] <= '0;
        end else begin
            state        <= state_nx;
            winner_valid <= state == UPDATE;
            scan         <= state == SEARCH ? scan + 1'b1 : '0;
            if ((state == SEARCH || state == UPDATE) && learning_done)
                pending <= 1'b1;
            else if (state == ASSOC)
                pending <= 1'b0;
            if (state == UPDATE) begin
                if (insert && !full) begin
                    node_count <= node_count + 1'b1;
                    winner_idx <= IDX_W'(node_count);
                end else begin
                    // a refused insertion on a full memory falls back to a winner update
                    winner_idx <= idx1;
                    overflow   <= overflow | insert;
                    if (valid2) begin
                        edges[idx1] <= edges[idx1] | (NODES'(1) << idx2);
                        edges[idx2] <= edges[idx2] | (NODES'(1) << idx1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            xr <= x;
            cr <= c;
        end
        if (state == UPDATE) begin
            if (insert && !full) begin
                w[IDX_W'(node_count)]   <= xr;
                cls[IDX_W'(node_count)] <= cr;
            end else begin
                w[idx1] <= w_upd;
            end
        end
    end
endmodule

// File: tb/tb_gam_memory_layer_param.sv
// tb_gam_memory_layer_param: directed self-checking bench for the GAM memory layer.
module tb_gam_memory_layer_param;
    logic        clk = 1'b0, reset = 1'b1;
    logic [63:0] x = '0;
    logic [3:0]  c = '0;
    logic        x_valid = 1'b0, x_ready;
    logic [18:0] thresh = '0;
    logic        learning_done = 1'b0, assoc_learning_done = 1'b0, assoc_learning_start;
    logic [4:0]  node_count;
    logic [3:0]  winner_idx;
    logic        winner_valid, overflow;
    int          total = 0, bad = 0, lat = 0;

    always #5 clk = ~clk;

    gam_memory_layer_param dut (
        .clk                  (clk),
        .reset                (reset),
        .x                    (x),
        .c                    (c),
        .x_valid              (x_valid),
        .x_ready              (x_ready),
        .thresh               (thresh),
        .learning_done        (learning_done),
        .assoc_learning_done  (assoc_learning_done),
        .assoc_learning_start (assoc_learning_start),
        .node_count           (node_count),
        .winner_idx           (winner_idx),
        .winner_valid         (winner_valid),
        .overflow             (overflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] v, input logic [3:0] cl, input logic [18:0] th);
        @(negedge clk);
        x = {8{v}};
        c = cl;
        thresh = th;
        x_valid = 1'b1;
        @(posedge clk);
        #1 x_valid = 1'b0;
        lat = 0;
        while (!winner_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_x_ready", x_ready, 1);
        chk("rst_start", assoc_learning_start, 0);
        chk("rst_count", node_count, 0);
        chk("rst_winner", winner_idx, 0);
        chk("rst_wvalid", winner_valid, 0);
        chk("rst_overflow", overflow, 0);

        send(8'd10, 4'd1, 19'd1000);
        chk("s1_lat", lat, 2);
        chk("s1_count", node_count, 1);
        chk("s1_winner", winner_idx, 0);

        send(8'd12, 4'd1, 19'd1000);
        chk("s2_lat", lat, 2);
        chk("s2_count", node_count, 2);
        chk("s2_winner", winner_idx, 1);
        chk("s2_edge0", dut.edges[0], 16'h0000);
        chk("s2_edge1", dut.edges[1], 16'h0000);

        send(8'd11, 4'd1, 19'd1000);
        chk("s3_lat", lat, 3);
        chk("s3_tie_winner", winner_idx, 0);
        chk("s3_count", node_count, 2);
        chk("s3_w0", dut.w[0], {8{8'd10}});
        chk("s3_edge0", dut.edges[0], 16'h0002);
        chk("s3_edge1", dut.edges[1], 16'h0001);

        send(8'd18, 4'd1, 19'd1000);
        chk("s4_winner", winner_idx, 1);
        chk("s4_w1", dut.w[1], {8{8'd13}});

        send(8'd0, 4'd1, 19'd2000);
        chk("s5_lat", lat, 3);
        chk("s5_winner", winner_idx, 0);
        chk("s5_w0_neg_step", dut.w[0], {8{8'd7}});

        send(8'd10, 4'd2, 19'd1000);
        chk("s6_class_insert", winner_idx, 2);
        chk("s6_count", node_count, 3);

        send(8'd9, 4'd2, 19'd8);
        chk("s7_lat", lat, 4);
        chk("s7_eq_thresh_upd", winner_idx, 2);
        chk("s7_count", node_count, 3);
        chk("s7_w2", dut.w[2], {8{8'd9}});
        chk("s7_edge0", dut.edges[0], 16'h0006);
        chk("s7_edge2", dut.edges[2], 16'h0001);

        send(8'd13, 4'd2, 19'd7);
        chk("s8_winner", winner_idx, 3);
        chk("s8_count", node_count, 4);

        for (int i = 4; i < 16; i++) begin
            send(8'(50 + 10*i), 4'(i), 19'd0);
            chk("fill_lat", lat, i + 1);
            chk("fill_winner", winner_idx, i);
            chk("fill_count", node_count, i + 1);
        end
        chk("fill_overflow", overflow, 0);

        send(8'd250, 4'd15, 19'd0);
        chk("full_lat", lat, 17);
        chk("full_overflow", overflow, 1);
        chk("full_count", node_count, 16);
        chk("full_winner", winner_idx, 15);
        chk("full_w15", dut.w[15], {8{8'd212}});

        @(negedge clk);
        x = {8{8'd200}};
        c = 4'd15;
        x_valid = 1'b1;
        @(posedge clk);
        #1 x_valid = 1'b0;
        lat = 0;
        learning_done = 1'b1;
        while (!winner_valid && lat < 40) begin
            @(posedge clk);
            #1 learning_done = 1'b0;
            lat++;
        end
        chk("ld_lat", lat, 17);
        chk("ld_winner", winner_idx, 14);
        chk("ld_w14", dut.w[14], {8{8'd192}});
        chk("ld_ready_idle", x_ready, 1);
        chk("ld_start_idle", assoc_learning_start, 0);
        @(posedge clk);
        #1;
        chk("assoc_start", assoc_learning_start, 1);
        chk("assoc_ready", x_ready, 0);
        chk("assoc_wvalid", winner_valid, 0);
        @(negedge clk);
        assoc_learning_done = 1'b1;
        @(posedge clk);
        #1 assoc_learning_done = 1'b0;
        chk("done_start", assoc_learning_start, 0);
        chk("done_ready", x_ready, 0);
        x_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 x_valid = 1'b0;
        chk("done_count_hold", node_count, 16);
        chk("done_overflow_hold", overflow, 1);
        chk("done_winner_hold", winner_idx, 14);
        chk("done_ready_hold", x_ready, 0);

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst2_count", node_count, 0);
        chk("rst2_overflow", overflow, 0);
        chk("rst2_ready", x_ready, 1);
        chk("rst2_edge0", dut.edges[0], 16'h0000);
        assoc_learning_done = 1'b1;
        @(negedge clk);
        assoc_learning_done = 1'b0;
        @(negedge clk);
        chk("idle_ignore_adone", x_ready, 1);
        chk("idle_no_start", assoc_learning_start, 0);

        send(8'd5, 4'd3, 19'd0);
        chk("s9_lat", lat, 2);
        chk("s9_count", node_count, 1);
        @(negedge clk);
        learning_done = 1'b1;
        @(negedge clk);
        learning_done = 1'b0;
        chk("assoc2_start", assoc_learning_start, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst3_start", assoc_learning_start, 0);
        chk("rst3_ready", x_ready, 1);
        chk("rst3_count", node_count, 0);
        chk("rst3_winner", winner_idx, 0);
        @(negedge clk);
        chk("rst3_stay_idle", x_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
